// File: rtl/arvi_bus_pkg.sv
// rtl/arvi_bus_pkg.sv - shared bus widths, arbiter state type and timeout constant
//
// Purpose: common definitions for the memory-mapped bus blocks.
// Contents: BUS_ADDR_W, BUS_DATA_W, BUS_BE_W, arb_state_t, TIMEOUT_RD_DATA.
package arvi_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Read data returned to a master whose transaction was forcibly terminated.
  localparam logic [BUS_DATA_W-1:0] TIMEOUT_RD_DATA = 32'h0;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
//
// Purpose: pick the first set request scanning upward (mod N) from last+1.
// Ports:
//   req   in  N       request vector
//   last  in  IW      index of the previous winner
//   win   out IW      winning index (0 when no request)
//   valid out 1       at least one request is set
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] win,
  output logic          valid
);

  int idx;

  // Scan from the farthest candidate back toward last+1 so that the
  // closest requester after the previous winner overwrites the others.
  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        win   = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter for one shared memory-mapped slave bus
//
// Purpose: grants one of N_MASTERS request/ack masters per transaction,
// re-arbitrating after every ack, with an optional hung-transaction timeout.
// Optional feature macro: ARB_TIMEOUT_EN (timeout counter and o_err).
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_bus_en, i_wr_rd            per-master request and write/read select
//   i_wr_data, i_addr, i_byte_en per-master write data, address, byte enables
//   o_ack, o_rd_data             per-master ack pulse and read data
//   o_grant                      one-hot current owner
//   o_err                        timeout termination pulse
//   i_ack, i_rd_data             slave ack and read data
//   o_bus_en, o_wr_en            slave request and write strobe
//   o_wr_data, o_addr, o_byte_en slave write data, address, byte enables
module bus_rr_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_MASTERS-1:0]            i_bus_en,
  input  logic [N_MASTERS-1:0]            i_wr_rd,
  input  logic [BUS_DATA_W*N_MASTERS-1:0] i_wr_data,
  input  logic [BUS_ADDR_W*N_MASTERS-1:0] i_addr,
  input  logic [BUS_BE_W*N_MASTERS-1:0]   i_byte_en,
  output logic [N_MASTERS-1:0]            o_ack,
  output logic [BUS_DATA_W*N_MASTERS-1:0] o_rd_data,
  output logic [N_MASTERS-1:0]            o_grant,
  output logic                            o_err,
  input  logic                            i_ack,
  input  logic [BUS_DATA_W-1:0]           i_rd_data,
  output logic                            o_bus_en,
  output logic                            o_wr_en,
  output logic [BUS_DATA_W-1:0]           o_wr_data,
  output logic [BUS_ADDR_W-1:0]           o_addr,
  output logic [BUS_BE_W-1:0]             o_byte_en
);

  localparam int IW = $clog2(N_MASTERS);

  arb_state_t    state, nxt_state;
  logic [IW-1:0] grant_idx, nxt_grant_idx;
  logic [IW-1:0] last_grant, nxt_last_grant;
  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          timeout_hit;

  rr_picker #(.N(N_MASTERS), .IW(IW)) u_picker (
    .req   (i_bus_en),
    .last  (last_grant),
    .win   (pick_idx),
    .valid (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // An ack in the terminal cycle wins over the forced termination.
  assign timeout_hit = (to_cnt == 8'(TIMEOUT_CYCLES - 1)) && !i_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      to_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      to_cnt <= '0;
    end else if (!i_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ARB_IDLE;
      grant_idx  <= '0;
      last_grant <= IW'(N_MASTERS - 1);
    end else begin
      state      <= nxt_state;
      grant_idx  <= nxt_grant_idx;
      last_grant <= nxt_last_grant;
    end
  end

  always_comb begin
    nxt_state      = state;
    nxt_grant_idx  = grant_idx;
    nxt_last_grant = last_grant;
    o_ack          = '0;
    o_rd_data      = '0;
    o_grant        = '0;
    o_err          = 1'b0;
    o_bus_en       = 1'b0;
    o_wr_en        = 1'b0;
    o_wr_data      = '0;
    o_addr         = '0;
    o_byte_en      = '0;

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          nxt_state      = ARB_BUSY;
          nxt_grant_idx  = pick_idx;
          nxt_last_grant = pick_idx;
        end
      end

      ARB_BUSY: begin
        o_grant[grant_idx] = 1'b1;
        o_bus_en  = i_bus_en[grant_idx];
        o_wr_en   = i_bus_en[grant_idx] & i_wr_rd[grant_idx];
        o_wr_data = i_wr_data[BUS_DATA_W*int'(grant_idx) +: BUS_DATA_W];
        o_addr    = i_addr[BUS_ADDR_W*int'(grant_idx) +: BUS_ADDR_W];
        o_byte_en = i_byte_en[BUS_BE_W*int'(grant_idx) +: BUS_BE_W];
        o_rd_data[BUS_DATA_W*int'(grant_idx) +: BUS_DATA_W] = i_rd_data;

        if (i_ack) begin
          o_ack[grant_idx] = 1'b1;
          nxt_state        = ARB_IDLE;
        end else if (!i_bus_en[grant_idx]) begin
          // Master abandoned the transaction: release without an ack.
          nxt_state = ARB_IDLE;
        end else if (timeout_hit) begin
          o_ack[grant_idx] = 1'b1;
          o_err            = 1'b1;
          o_bus_en         = 1'b0;
          o_wr_en          = 1'b0;
          o_rd_data[BUS_DATA_W*int'(grant_idx) +: BUS_DATA_W] = TIMEOUT_RD_DATA;
          nxt_state        = ARB_IDLE;
        end
      end

      default: nxt_state = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - directed self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic [3:0]    i_bus_en = '0;
  logic [3:0]    i_wr_rd = '0;
  logic [127:0]  i_wr_data = '0;
  logic [127:0]  i_addr = '0;
  logic [15:0]   i_byte_en = '0;
  logic [3:0]    o_ack;
  logic [127:0]  o_rd_data;
  logic [3:0]    o_grant;
  logic          o_err;
  logic          i_ack = 1'b0;
  logic [31:0]   i_rd_data = '0;
  logic          o_bus_en;
  logic          o_wr_en;
  logic [31:0]   o_wr_data;
  logic [31:0]   o_addr;
  logic [3:0]    o_byte_en;

  int total = 0;
  int bad = 0;

  bus_rr_arbiter #(.N_MASTERS(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_bus_en  (i_bus_en),
    .i_wr_rd   (i_wr_rd),
    .i_wr_data (i_wr_data),
    .i_addr    (i_addr),
    .i_byte_en (i_byte_en),
    .o_ack     (o_ack),
    .o_rd_data (o_rd_data),
    .o_grant   (o_grant),
    .o_err     (o_err),
    .i_ack     (i_ack),
    .i_rd_data (i_rd_data),
    .o_bus_en  (o_bus_en),
    .o_wr_en   (o_wr_en),
    .o_wr_data (o_wr_data),
    .o_addr    (o_addr),
    .o_byte_en (o_byte_en)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  task automatic test_reset;
    i_bus_en = '0;
    i_ack = 1'b0;
    do_reset();
    #1;
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
    total++; if (o_bus_en !== 1'b0 || o_wr_en !== 1'b0) begin bad++; $display("FAIL reset_bus_en: got %b/%b want 0/0", o_bus_en, o_wr_en); end
    total++; if (o_ack !== 4'b0000 || o_err !== 1'b0) begin bad++; $display("FAIL reset_ack_err: got %b/%b want 0000/0", o_ack, o_err); end
    total++; if (o_rd_data !== 128'h0 || o_addr !== 32'h0) begin bad++; $display("FAIL reset_data: got %h/%h want 0", o_rd_data, o_addr); end
  endtask

  task automatic test_single_read;
    int acks;
    acks = 0;
    i_addr[64 +: 32] = 32'h0000_2040;
    i_byte_en[8 +: 4] = 4'hF;
    i_wr_rd = 4'b0000;
    i_bus_en = 4'b0100;
    #1;
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL single_idle_grant: got %b want 0000", o_grant); end
    step();
    total++; if (o_grant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", o_grant); end
    total++; if (o_addr !== 32'h0000_2040 || o_bus_en !== 1'b1 || o_wr_en !== 1'b0) begin bad++; $display("FAIL single_slave_side: got addr=%h en=%b wr=%b want 00002040/1/0", o_addr, o_bus_en, o_wr_en); end
    total++; if (o_byte_en !== 4'hF) begin bad++; $display("FAIL single_byte_en: got %h want f", o_byte_en); end
    for (int c = 0; c < 3; c++) begin
      if (o_ack != 4'b0000) acks++;
      step();
    end
    i_rd_data = 32'hCAFE_0001;
    i_ack = 1'b1;
    #1;
    if (o_ack != 4'b0000) acks++;
    total++; if (o_ack !== 4'b0100) begin bad++; $display("FAIL single_ack: got %b want 0100", o_ack); end
    total++; if (o_rd_data !== {32'h0, 32'hCAFE_0001, 32'h0, 32'h0}) begin bad++; $display("FAIL single_rd_data: got %h want word2=cafe0001", o_rd_data); end
    step();
    i_ack = 1'b0;
    i_bus_en = 4'b0000;
    i_rd_data = '0;
    #1;
    if (o_ack != 4'b0000) acks++;
    total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL single_back_idle: got %b want 0000", o_grant); end
    total++; if (acks !== 1) begin bad++; $display("FAIL single_ack_count: got %0d want 1", acks); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp;
    do_reset();
    i_bus_en = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp = 4'b0001 << (i % 4);
      step();
      total++; if (o_grant !== exp) begin bad++; $display("FAIL rr_grant_%0d: got %b want %b", i, o_grant, exp); end
      step();
      i_ack = 1'b1;
      #1;
      total++; if (o_ack !== exp) begin bad++; $display("FAIL rr_ack_%0d: got %b want %b", i, o_ack, exp); end
      step();
      i_ack = 1'b0;
      #1;
      total++; if (o_grant !== 4'b0000) begin bad++; $display("FAIL rr_idle_%0d: got %b want 0000", i, o_grant); end
    end
    i_bus_en = 4'b0000;
    step();
  endtask

  task automatic test_back_to_back_drop;
    // last_grant is 0 here, so master 1 wins over nobody else.
    i_bus_en = 4'b0010;
    step();
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL drop_grant1: got %b want 0010", o_grant); end
    i_bus_en = 4'b1010;
    step();
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL drop_hold_grant: got %b want 0010", o_grant); end
    i_bus_en = 4'b0010;
    step();
    i_ack = 1'b1;
    #1;
    total++; if (o_ack !== 4'b0010) begin bad++; $display("FAIL drop_ack: got %b want 0010", o_ack); end
    step();
    i_ack = 1'b0;
    #1;
    total++; if (o_grant !== 4'b0000 || o_ack !== 4'b0000) begin bad++; $display("FAIL drop_idle: got grant=%b ack=%b want 0000/0000", o_grant, o_ack); end
    step();
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL drop_regrant1: got %b want 0010", o_grant); end
    i_ack = 1'b1;
    #1;
    total++; if (o_ack !== 4'b0010) begin bad++; $display("FAIL drop_no_stray3: got %b want 0010", o_ack); end
    step();
    i_ack = 1'b0;
    i_bus_en = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_wr_rd = 4'b0001;
    i_wr_data[0 +: 32] = 32'h1234_5678;
    i_addr[0 +: 32] = 32'h0000_0100;
    i_bus_en = 4'b0001;
    step();
    total++; if (o_wr_en !== 1'b1 || o_wr_data !== 32'h1234_5678) begin bad++; $display("FAIL rstmid_write: got wr=%b data=%h want 1/12345678", o_wr_en, o_wr_data); end
    i_bus_en = 4'b0011;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
    total++; if (o_bus_en !== 1'b0 || o_grant !== 4'b0000 || o_ack !== 4'b0000) begin bad++; $display("FAIL rstmid_after: got en=%b grant=%b ack=%b want 0/0000/0000", o_bus_en, o_grant, o_ack); end
    step();
    total++; if (o_grant !== 4'b0001) begin bad++; $display("FAIL rstmid_regrant0: got %b want 0001", o_grant); end
    i_ack = 1'b1;
    i_bus_en = 4'b0001;
    step();
    i_ack = 1'b0;
    i_bus_en = 4'b0000;
    i_wr_rd = 4'b0000;
    step();
  endtask

  task automatic test_abort;
    // last_grant is 0: master 1 is next.
    i_bus_en = 4'b0010;
    step();
    total++; if (o_grant !== 4'b0010) begin bad++; $display("FAIL abort_grant: got %b want 0010", o_grant); end
    i_bus_en = 4'b0000;
    #1;
    total++; if (o_ack !== 4'b0000 || o_bus_en !== 1'b0) begin bad++; $display("FAIL abort_no_ack: got ack=%b en=%b want 0000/0", o_ack, o_bus_en); end
    step();
    total++; if (o_grant !== 4'b0000 || o_ack !== 4'b0000) begin bad++; $display("FAIL abort_idle: got grant=%b ack=%b want 0000/0000", o_grant, o_ack); end
    i_bus_en = 4'b0110;
    step();
    total++; if (o_grant !== 4'b0100) begin bad++; $display("FAIL abort_ptr_advanced: got %b want 0100", o_grant); end
    i_ack = 1'b1;
    i_bus_en = 4'b0100;
    step();
    i_ack = 1'b0;
    i_bus_en = 4'b0000;
    step();
  endtask

  task automatic test_timeout;
    // last_grant is 2: master 3 wins over master 0.
    i_rd_data = 32'hDEAD_BEEF;
    i_bus_en = 4'b1001;
    step();
    total++; if (o_grant !== 4'b1000) begin bad++; $display("FAIL to_grant3: got %b want 1000", o_grant); end
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      total++; if (o_ack !== 4'b0000 || o_err !== 1'b0) begin bad++; $display("FAIL to_early_%0d: got ack=%b err=%b want 0000/0", k, o_ack, o_err); end
      step();
    end
    total++; if (o_ack !== 4'b1000 || o_err !== 1'b1 || o_bus_en !== 1'b0) begin bad++; $display("FAIL to_fire: got ack=%b err=%b en=%b want 1000/1/0", o_ack, o_err, o_bus_en); end
    total++; if (o_rd_data !== 128'h0) begin bad++; $display("FAIL to_rd_zero: got %h want 0", o_rd_data); end
    step();
    i_bus_en = 4'b0001;
    #1;
    total++; if (o_grant !== 4'b0000 || o_err !== 1'b0) begin bad++; $display("FAIL to_idle: got grant=%b err=%b want 0000/0", o_grant, o_err); end
    step();
    total++; if (o_grant !== 4'b0001) begin bad++; $display("FAIL to_next_grant: got %b want 0001", o_grant); end
`else
    for (int k = 0; k < 20; k++) begin
      step();
      total++; if (o_err !== 1'b0 || o_grant !== 4'b1000 || o_ack !== 4'b0000) begin bad++; $display("FAIL noto_hold_%0d: got err=%b grant=%b ack=%b want 0/1000/0000", k, o_err, o_grant, o_ack); end
    end
    i_ack = 1'b1;
    #1;
    total++; if (o_ack !== 4'b1000 || o_rd_data[96 +: 32] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL noto_ack: got ack=%b rd=%h want 1000/deadbeef", o_ack, o_rd_data[96 +: 32]); end
    step();
    i_ack = 1'b0;
    i_bus_en = 4'b0001;
    step();
    total++; if (o_grant !== 4'b0001) begin bad++; $display("FAIL noto_next_grant: got %b want 0001", o_grant); end
`endif
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    i_bus_en = 4'b0000;
    i_rd_data = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back_drop();
    test_reset_mid();
    test_abort();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter sharing one 32-bit memory-mapped slave bus between N_MASTERS bus masters, e.g. instruction fetch, data port, debug and DMA. Each master port uses the same request/ack protocol as the slave side, so the block drops between cores and the bus interconnect without adapters. The arbiter holds the grant for the duration of one transaction. It re-arbitrates after every ack and optionally terminates hung transactions with an error response.

## Interface
- N_MASTERS, 4: number of requesting masters (2..8).
- TIMEOUT_CYCLES, 255: busy cycles without i_ack before forced termination (only with timeout compiled in); 8-bit counter.
- i_clk  in  1  clock.
- i_rst  in  1  one clock; reset is synchronous and active-high.
- i_bus_en  in  N_MASTERS  per-master request; held until the master sees its ack.
- i_wr_rd  in  N_MASTERS  per-master write (1) / read (0).
- i_wr_data  in  32*N_MASTERS  per-master write data, master k at bits [32k+31:32k].
- i_addr  in  32*N_MASTERS  per-master address, same packing.
- i_byte_en  in  4*N_MASTERS  per-master byte enables, master k at [4k+3:4k].
- o_ack  out  N_MASTERS  per-master ack, one-cycle pulse.
- o_rd_data  out  32*N_MASTERS  per-master read data; zero for non-granted masters.
- o_grant  out  N_MASTERS  one-hot current owner; zero when idle.
- o_err  out  1  one-cycle pulse when a transaction is timed out.
- i_ack  in  1  slave ack.
- i_rd_data  in  32  slave read data.
- o_bus_en, o_wr_en  out  1  slave request and write strobe.
- o_wr_data, o_addr  out  32  slave write data and address.
- o_byte_en  out  4  slave byte enables.

## Operation
- The FSM has two states, IDLE and BUSY. It uses registered state, grant index and last-grant pointer.
- IDLE: if any i_bus_en bit is set, pick the first requester scanning upward (mod N_MASTERS) from last_grant+1. Register the grant, set last_grant to the winner, and go to BUSY. If no bit is set, stay in IDLE.
- BUSY: the slave outputs are a combinational mux of the granted master's inputs.
  - o_ack[g] = i_ack and o_rd_data[g] = i_rd_data. All other masters see 0.
  - On i_ack, go to IDLE.
  - If the granted master drops i_bus_en without an ack (abort), go to IDLE with no ack.
- Requests from non-granted masters are ignored until IDLE. A loser keeps i_bus_en high and gets served within N_MASTERS-1 transactions.
- IDLE outputs: all slave-side outputs, o_ack, o_rd_data, o_grant and o_err are 0.
- Simultaneous requests in IDLE: round-robin order is the only tie-break.
- Reset:
  - state=IDLE, last_grant=N_MASTERS-1 (master 0 has first priority), timeout counter=0.
  - All outputs 0 from the first cycle after reset is sampled.
  - Reset mid-transaction drops o_bus_en and does not emit an ack.

## Timing
- A request first seen in IDLE at cycle t gives o_grant and o_bus_en asserted at cycle t+1.
- Ack path is combinational: i_ack at cycle t gives o_ack[g] at cycle t, and the state is IDLE at t+1.
- The mandatory IDLE cycle after each ack lets the finished master drop i_bus_en before arbitration. Minimum transaction spacing is 2 cycles plus slave latency.
- o_grant is stable for the whole BUSY period.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without i_ack.
  - When the counter equals TIMEOUT_CYCLES-1 and there is still no i_ack, in that same cycle: o_ack[g]=1, o_rd_data[g]=0, o_err=1, o_bus_en=0. The state then goes to IDLE.
  - An i_ack arriving in that same cycle wins: a normal ack, no o_err.
- ARB_TIMEOUT_EN undefined: the arbiter waits indefinitely and o_err is tied to 0.

## Structure
- Shared package arvi_bus_pkg holds:
  - BUS_ADDR_W=32, BUS_DATA_W=32, BUS_BE_W=4.
  - The arbiter state typedef (ARB_IDLE, ARB_BUSY).
  - The timeout read-data constant (32'h0).
- Sub-module rr_picker is purely combinational. It takes the request vector and last_grant, and outputs a winner index and a valid flag. It is reusable by future interrupt and DMA schedulers.

## Test plan
- Single master 2 requests a read; the slave acks 3 cycles after o_bus_en with rd_data 32'hCAFE_0001 -> o_grant=4'b0100 from t+1, o_addr equals i_addr2, o_ack[2] pulses once, o_rd_data word 2 = 32'hCAFE_0001, back to IDLE.
- All 4 masters request continuously after reset, with the slave acking in 1 cycle -> grant order 0,1,2,3,0, each transaction 3 cycles apart with an IDLE cycle between.
- Masters 1 and 3 request while master 1 is BUSY, then master 3 drops its request before the ack -> after the ack only master 1 re-requesting is granted; no stray o_ack[3].
- Reset is asserted while BUSY on master 0 with a write pending -> the next cycle has o_bus_en=0 and o_grant=0, no ack; the next request goes to master 0.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, the slave never acks -> in the 8th BUSY cycle o_ack[g]=1, o_err=1, rd_data=0; the next master is granted afterward.
- Granted master aborts (drops i_bus_en) with no ack -> IDLE next cycle, o_ack stays 0, and the round-robin pointer still advances past it.
